// File: rtl/sequential_nonrestoring_divider.sv
// -----------------------------------------------------------------------------
// sequential_nonrestoring_divider
//
// Signed two's-complement divider built on a radix-2 non-restoring core.
// One quotient bit is produced per enabled clock. Results truncate toward
// zero (the remainder takes the sign of the dividend). Every operation,
// including divide-by-zero and the MIN/-1 overflow case, has the same latency:
// the accepting edge, DATA_WIDTH divide steps and one restore/sign step.
//
// Ports
//   clk_i            rising-edge clock
//   rst_i            asynchronous, active-high reset
//   clk_en_i         clock enable; all registers hold while low
//   valid_entry_i    one-cycle strobe qualifying the operands (IDLE/DONE only)
//   operand_A_i      signed dividend
//   operand_B_i      signed divisor
//   quotient_o       signed quotient, held until the next result
//   remainder_o      signed remainder, held until the next result
//   divide_by_zero_o set with a result whose divisor was zero
//   data_valid_o     one-cycle strobe marking a new result
//   busy_o           high while a division is in progress
// -----------------------------------------------------------------------------
module sequential_nonrestoring_divider #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clk_en_i,
    input  logic                  valid_entry_i,
    input  logic [DATA_WIDTH-1:0] operand_A_i,
    input  logic [DATA_WIDTH-1:0] operand_B_i,
    output logic [DATA_WIDTH-1:0] quotient_o,
    output logic [DATA_WIDTH-1:0] remainder_o,
    output logic                  divide_by_zero_o,
    output logic                  data_valid_o,
    output logic                  busy_o
);

    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        RESTORE,
        DONE
    } state_t;

    state_t state;

    // Partial remainder is one bit wider than the operands so that the
    // shifted value 2*P + bit always fits for any |B| up to 2^(DATA_WIDTH-1).
    logic signed [DATA_WIDTH:0]   p;
    logic        [DATA_WIDTH-1:0] q;          // dividend magnitude shifting out, quotient bits shifting in
    logic        [DATA_WIDTH-1:0] b_abs;
    logic                         a_neg;      // remainder sign
    logic                         q_neg;      // quotient sign
    logic                         b_zero;
    logic        [CW-1:0]         count;

    // Operand magnitudes. The most negative value maps to 2^(DATA_WIDTH-1),
    // which is still representable as an unsigned DATA_WIDTH-bit magnitude.
    logic [DATA_WIDTH-1:0] a_abs_in;
    logic [DATA_WIDTH-1:0] b_abs_in;

    assign a_abs_in = operand_A_i[DATA_WIDTH-1] ? -operand_A_i : operand_A_i;
    assign b_abs_in = operand_B_i[DATA_WIDTH-1] ? -operand_B_i : operand_B_i;

    // One non-restoring step: shift {P,Q} left, then subtract |B| while the
    // partial remainder is non-negative and add it back while negative.
    logic signed [DATA_WIDTH:0] b_ext;
    logic signed [DATA_WIDTH:0] p_shift;
    logic signed [DATA_WIDTH:0] p_step;
    logic signed [DATA_WIDTH:0] p_fix;

    assign b_ext   = {1'b0, b_abs};
    assign p_shift = {p[DATA_WIDTH-1:0], q[DATA_WIDTH-1]};
    assign p_step  = p_shift[DATA_WIDTH] ? (p_shift + b_ext) : (p_shift - b_ext);

    // Final correction: a negative partial remainder is one |B| too low.
    assign p_fix   = p[DATA_WIDTH] ? (p + b_ext) : p;

    // NOTE: every register here is state, so it is written only with
    // non-blocking assignments; blocking ones would race with the readers
    // of the old value in the same edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: the datapath registers are reset as well so the bench and
            // downstream logic never see X after a reset abandons an operation.
            state            <= IDLE;
            p                <= '0;
            q                <= '0;
            b_abs            <= '0;
            a_neg            <= 1'b0;
            q_neg            <= 1'b0;
            b_zero           <= 1'b0;
            count            <= '0;
            quotient_o       <= '0;
            remainder_o      <= '0;
            divide_by_zero_o <= 1'b0;
            data_valid_o     <= 1'b0;
            busy_o           <= 1'b0;
        end else if (clk_en_i) begin
            data_valid_o <= 1'b0;
            case (state)
                // DONE accepts a new operand pair exactly like IDLE, which
                // gives back-to-back operation without an idle gap.
                IDLE, DONE: begin
                    if (valid_entry_i) begin
                        state  <= DIVIDE;
                        busy_o <= 1'b1;
                        p      <= '0;
                        q      <= a_abs_in;
                        b_abs  <= b_abs_in;
                        a_neg  <= operand_A_i[DATA_WIDTH-1];
                        q_neg  <= operand_A_i[DATA_WIDTH-1] ^ operand_B_i[DATA_WIDTH-1];
                        b_zero <= (operand_B_i == '0);
                        count  <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end

                DIVIDE: begin
                    p     <= p_step;
                    q     <= {q[DATA_WIDTH-2:0], ~p_step[DATA_WIDTH]};
                    count <= count + CW'(1);
                    if (count == CW'(DATA_WIDTH - 1)) begin
                        state <= RESTORE;
                    end
                end

                RESTORE: begin
                    // With |B| = 0 the core never subtracts, so P ends as |A|
                    // and the signed remainder is A itself; only the quotient
                    // needs forcing to all ones.
                    quotient_o       <= b_zero ? '1 : (q_neg ? -q : q);
                    remainder_o      <= a_neg ? -p_fix[DATA_WIDTH-1:0] : p_fix[DATA_WIDTH-1:0];
                    divide_by_zero_o <= b_zero;
                    data_valid_o     <= 1'b1;
                    busy_o           <= 1'b0;
                    state            <= DONE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequential_nonrestoring_divider.sv
// -----------------------------------------------------------------------------
// tb_sequential_nonrestoring_divider
//
// Directed bench for the signed sequential divider at DATA_WIDTH = 32.
// Inputs are driven 1 time unit after a rising edge and outputs are sampled
// at the same point, away from the active edge. Latency is counted in edges
// including the edge that samples valid_entry_i, so a plain operation
// reports 34 edges and 33 busy cycles.
// -----------------------------------------------------------------------------
module tb_sequential_nonrestoring_divider;

    localparam int W = 32;

    logic         clk_i;
    logic         rst_i;
    logic         clk_en_i;
    logic         valid_entry_i;
    logic [W-1:0] operand_A_i;
    logic [W-1:0] operand_B_i;
    logic [W-1:0] quotient_o;
    logic [W-1:0] remainder_o;
    logic         divide_by_zero_o;
    logic         data_valid_o;
    logic         busy_o;

    int total = 0;
    int bad   = 0;

    sequential_nonrestoring_divider #(.DATA_WIDTH(W)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .clk_en_i         (clk_en_i),
        .valid_entry_i    (valid_entry_i),
        .operand_A_i      (operand_A_i),
        .operand_B_i      (operand_B_i),
        .quotient_o       (quotient_o),
        .remainder_o      (remainder_o),
        .divide_by_zero_o (divide_by_zero_o),
        .data_valid_o     (data_valid_o),
        .busy_o           (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Present one operand pair for exactly one edge; returns 1 unit after it.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        valid_entry_i = 1'b1;
        operand_A_i   = a;
        operand_B_i   = b;
        @(posedge clk_i);
        #1;
        valid_entry_i = 1'b0;
    endtask

    // Wait for data_valid_o after launch(). Optionally pulses a bogus strobe
    // (A=5, B=0) at edge pulse_at and drops clk_en_i for stall_len edges
    // starting after edge stall_at. Bounded at 200 edges.
    task automatic wait_result(input int pulse_at, input int stall_at, input int stall_len,
                               output int lat, output int busy_cnt);
        lat      = 1;
        busy_cnt = busy_o ? 1 : 0;
        while (!data_valid_o && lat < 200) begin
            @(posedge clk_i);
            #1;
            lat++;
            if (lat == pulse_at) begin
                valid_entry_i = 1'b1;
                operand_A_i   = 32'd5;
                operand_B_i   = 32'd0;
            end else begin
                valid_entry_i = 1'b0;
            end
            if (stall_len > 0 && lat == stall_at)             clk_en_i = 1'b0;
            if (stall_len > 0 && lat == stall_at + stall_len) clk_en_i = 1'b1;
            if (busy_o) busy_cnt++;
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
        int lat;
        int bc;
        @(posedge clk_i);
        #1;
        launch(a, b);
        wait_result(0, 0, 0, lat, bc);
        check({tag, "_lat"},  lat, 32'd34);
        check({tag, "_q"},    quotient_o, eq);
        check({tag, "_r"},    remainder_o, er);
        check({tag, "_dbz"},  32'(divide_by_zero_o), 32'(edbz));
        check({tag, "_busy"}, bc, 32'd33);
        @(posedge clk_i);
        #1;
        check({tag, "_dv_one"}, 32'(data_valid_o), 32'd0);
        check({tag, "_hold"},   quotient_o, eq);
    endtask

    // Independent reference: SV signed division truncates toward zero.
    function automatic logic [63:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        logic signed [W-1:0] rq;
        logic signed [W-1:0] rr;
        sa = a;
        sb = b;
        if (b == '0) begin
            rq = -1;
            rr = sa;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            rq = sa;
            rr = 0;
        end else begin
            rq = sa / sb;
            rr = sa % sb;
        end
        return {rq, rr};
    endfunction

    initial begin
        int lat;
        int bc;
        int dv_seen;
        int busy_seen;
        logic [63:0] exp_qr;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst_i         = 1'b0;
        clk_en_i      = 1'b1;
        valid_entry_i = 1'b0;
        operand_A_i   = '0;
        operand_B_i   = '0;

        // Asynchronous reset: outputs clear before any clock edge.
        #1 rst_i = 1'b1;
        #2;
        check("rst_q",    quotient_o, 32'd0);
        check("rst_r",    remainder_o, 32'd0);
        check("rst_dbz",  32'(divide_by_zero_o), 32'd0);
        check("rst_dv",   32'(data_valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Basic and sign combinations
        run_op("p100_p7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        run_op("n100_p7", -32'sd100, 32'd7, -32'sd14, -32'sd2, 1'b0);
        run_op("p100_n7", 32'd100, -32'sd7, -32'sd14, 32'd2, 1'b0);
        run_op("n100_n7", -32'sd100, -32'sd7, 32'd14, -32'sd2, 1'b0);

        // Corner cases
        run_op("p5_div0",  32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
        run_op("n5_div0",  -32'sd5, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
        run_op("min_n1",   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
        run_op("p7_p100",  32'd7, 32'd100, 32'd0, 32'd7, 1'b0);
        run_op("n7_p100",  -32'sd7, 32'd100, 32'd0, 32'hFFFF_FFF9, 1'b0);
        run_op("max_p1",   32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd0, 1'b0);
        run_op("min_min",  32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0, 1'b0);
        run_op("min_p2",   32'h8000_0000, 32'd2, 32'hC000_0000, 32'd0, 1'b0);
        run_op("max_min",  32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'h7FFF_FFFF, 1'b0);

        // Back-to-back: second strobe in the DONE cycle
        @(posedge clk_i);
        #1;
        launch(32'd100, 32'd7);
        wait_result(0, 0, 0, lat, bc);
        check("b2b1_lat", lat, 32'd34);
        check("b2b1_q",   quotient_o, 32'd14);
        launch(-32'sd100, -32'sd7);
        check("b2b_no_gap", 32'(busy_o), 32'd1);
        check("b2b_dv_low", 32'(data_valid_o), 32'd0);
        wait_result(0, 0, 0, lat, bc);
        check("b2b2_lat", lat, 32'd34);
        check("b2b2_q",   quotient_o, 32'd14);
        check("b2b2_r",   remainder_o, -32'sd2);

        // Strobe mid-DIVIDE is ignored
        @(posedge clk_i);
        #1;
        launch(32'd1000, 32'd3);
        wait_result(10, 0, 0, lat, bc);
        check("ign_lat",  lat, 32'd34);
        check("ign_q",    quotient_o, 32'd333);
        check("ign_r",    remainder_o, 32'd1);
        check("ign_dbz",  32'(divide_by_zero_o), 32'd0);
        check("ign_busy", bc, 32'd33);

        // Clock enable low for 5 edges mid-DIVIDE
        @(posedge clk_i);
        #1;
        launch(-32'sd1000, 32'd3);
        wait_result(0, 10, 5, lat, bc);
        check("stall_lat",  lat, 32'd39);
        check("stall_busy", bc, 32'd38);
        check("stall_q",    quotient_o, -32'sd333);
        check("stall_r",    remainder_o, -32'sd1);

        // Reset around step 10 abandons the operation
        @(posedge clk_i);
        #1;
        launch(32'd100, 32'd7);
        repeat (9) @(posedge clk_i);
        #1 rst_i = 1'b1;
        #1;
        check("mid_rst_q",    quotient_o, 32'd0);
        check("mid_rst_r",    remainder_o, 32'd0);
        check("mid_rst_dbz",  32'(divide_by_zero_o), 32'd0);
        check("mid_rst_dv",   32'(data_valid_o), 32'd0);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        dv_seen   = 0;
        busy_seen = 0;
        repeat (40) begin
            @(posedge clk_i);
            #1;
            if (data_valid_o) dv_seen++;
            if (busy_o)       busy_seen++;
        end
        check("post_rst_no_dv",   dv_seen, 32'd0);
        check("post_rst_no_busy", busy_seen, 32'd0);
        run_op("fresh_n63_p8", -32'sd63, 32'd8, -32'sd7, -32'sd7, 1'b0);

        // Short random sweep against the reference model
        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
            exp_qr = ref_div(ra, rb);
            run_op("rnd", ra, rb, exp_qr[63:32], exp_qr[31:0], rb == '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
